// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-step control unit, fetch T0-T2 and execute T3-T5.
// Optional SEQ_SINGLE_STEP_EN adds step_req and holds after each step until requested.
module control_sequencer #(
  parameter int unsigned OPC_W = 5,
  parameter int unsigned ALU_W = 5,
  parameter logic [ALU_W-1:0] ALU_ADD = ALU_W'(5'b00001),
  parameter logic [OPC_W-1:0] OP_LDI = OPC_W'(5'b00001),
  parameter logic [OPC_W-1:0] OP_IN = OPC_W'(5'b10101),
  parameter logic [OPC_W-1:0] OP_OUT = OPC_W'(5'b10110),
  parameter logic [OPC_W-1:0] OP_NOP = OPC_W'(5'b11010),
  parameter logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011),
  parameter int unsigned CYC_PER_STEP = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear_n,
  input  logic run,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic step_req,
`endif
  output logic PC_select,
  output logic MAR_enable,
  output logic PC_increment_enable,
  output logic read,
  output logic MDR_enable,
  output logic MDR_select,
  output logic IR_enable,
  output logic Gra,
  output logic Grb,
  output logic BAout,
  output logic Y_enable,
  output logic c_select,
  output logic Z_enable,
  output logic Z_LO_select,
  output logic r_enable,
  output logic r_select,
  output logic outport_enable,
  output logic inport_select,
  output logic [ALU_W-1:0] alu_instruction,
  output logic [2:0] step,
  output logic halted,
  output logic fault,
  output logic illegal
);

  localparam int unsigned CW =
    (CYC_PER_STEP > 1) ? $clog2(CYC_PER_STEP) : 1;
  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYC_PER_STEP - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT, S_FAULT
  } state_e;

  state_e state_q, state_d, nxt, fetch;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [OPC_W-1:0] opc_q, opc_d, op;
  logic run_q, hold_q, hold_d;
  logic in_step, act, last, first, fin;
  logic is_ldi, is_in, is_out, is_nop, is_halt;

  assign in_step = (state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5});
  assign act = in_step && !hold_q;
  assign last = (cnt_q == CNT_LAST);
  assign first = (cnt_q == '0) && !hold_q;
  // Opcode is live only in the first T3 cycle, latched copy after that
  assign op = (state_q == S_T3 && first) ? ir_opcode : opc_q;
  assign is_ldi = (op == OP_LDI);
  assign is_in = (op == OP_IN);
  assign is_out = (op == OP_OUT);
  assign is_nop = (op == OP_NOP);
  assign is_halt = (op == OP_HALT);
  assign fin = act && last && (state_q != S_T1 || mem_ready);
  assign fetch = run ? S_T0 : S_IDLE;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      wait_q <= '0;
      opc_q <= '0;
      run_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
      opc_q <= opc_d;
      run_q <= run;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wait_d = (state_q == S_T1) ? wait_q : '0;
    opc_d = opc_q;
    hold_d = hold_q;
    nxt = fetch;
    PC_select = 1'b0;
    MAR_enable = 1'b0;
    PC_increment_enable = 1'b0;
    read = 1'b0;
    MDR_enable = 1'b0;
    MDR_select = 1'b0;
    IR_enable = 1'b0;
    Gra = 1'b0;
    Grb = 1'b0;
    BAout = 1'b0;
    Y_enable = 1'b0;
    c_select = 1'b0;
    Z_enable = 1'b0;
    Z_LO_select = 1'b0;
    r_enable = 1'b0;
    r_select = 1'b0;
    outport_enable = 1'b0;
    inport_select = 1'b0;
    alu_instruction = '0;
    step = 3'd7;
    halted = (state_q == S_HALT);
    fault = (state_q == S_FAULT);
    illegal = 1'b0;

    case (state_q)
      S_T0: nxt = S_T1;
      S_T1: nxt = S_T2;
      S_T2: nxt = S_T3;
      S_T3: begin
        if (is_ldi) nxt = S_T4;
        else if (is_halt) nxt = S_HALT;
      end
      S_T4: nxt = S_T5;
      default: nxt = fetch;
    endcase

    if (state_q == S_T3 && first) opc_d = ir_opcode;

    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_HALT: if (run && !run_q) state_d = S_T0;
      S_FAULT: state_d = S_FAULT;
      default: begin
        if (state_q == S_T1 && act && !mem_ready) begin
          if (wait_q == WAIT_LAST) state_d = S_FAULT;
          else wait_d = wait_q + WW'(1);
        end
        if (fin) begin
`ifdef SEQ_SINGLE_STEP_EN
          hold_d = 1'b1;
`else
          state_d = nxt;
          cnt_d = '0;
`endif
        end else if (act && !last) begin
          cnt_d = cnt_q + CW'(1);
        end
`ifdef SEQ_SINGLE_STEP_EN
        if (hold_q && step_req) begin
          state_d = nxt;
          cnt_d = '0;
          hold_d = 1'b0;
        end
`endif
      end
    endcase

    case (state_q)
      S_T0: begin
        step = 3'd0;
        PC_select = act;
        MAR_enable = fin;
      end
      S_T1: begin
        step = 3'd1;
        read = act;
        MDR_enable = fin;
        PC_increment_enable = fin;
      end
      S_T2: begin
        step = 3'd2;
        MDR_select = act;
        IR_enable = fin;
      end
      S_T3: begin
        step = 3'd3;
        if (act) begin
          unique case (1'b1)
            is_ldi: begin
              Grb = 1'b1;
              BAout = 1'b1;
              Y_enable = fin;
            end
            is_out: begin
              Gra = 1'b1;
              r_select = 1'b1;
              outport_enable = fin;
            end
            is_in: begin
              inport_select = 1'b1;
              Gra = 1'b1;
              r_enable = fin;
            end
            is_nop, is_halt: ;
            default: illegal = first;
          endcase
        end
      end
      S_T4: begin
        step = 3'd4;
        c_select = act;
        alu_instruction = act ? ALU_ADD : '0;
        Z_enable = fin;
      end
      S_T5: begin
        step = 3'd5;
        Z_LO_select = act;
        Gra = act;
        r_enable = fin;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that replaces hand-sequenced T-state stimulus with a real step FSM. It drives the datapath control strobes for instruction fetch (T0–T2) and for execute of ldi/in/out/nop/halt (T3–T5). Step length, opcode encodings and the memory-wait budget are parametrised. It sits beside the datapath; its outputs connect one-to-one to the datapath enable/select inputs.

Parameters:
OPC_W, 5, opcode width (IR[31:27])
ALU_W, 5, alu_instruction width
ALU_ADD, 5'b00001, ALU code issued for ldi address add
OP_LDI, 5'b00001, ldi opcode
OP_IN, 5'b10101, in opcode
OP_OUT, 5'b10110, out opcode
OP_NOP, 5'b11010, nop opcode
OP_HALT, 5'b11011, halt opcode
CYC_PER_STEP, 1, clocks per T-step (>=1)
MEM_TIMEOUT, 15, max clocks waiting on mem_ready in T1

Ports:
clk  in  1  clock, rising edge
clear_n  in  1  asynchronous active-low reset
run  in  1  level; start from IDLE / resume from HALTED (rising edge)
ir_opcode  in  OPC_W  IR[31:27], valid from T3 onward
mem_ready  in  1  memory read data valid
PC_select, MAR_enable, PC_increment_enable, read, MDR_enable, MDR_select, IR_enable, Gra, Grb, BAout, Y_enable, c_select, Z_enable, Z_LO_select, r_enable, r_select, outport_enable, inport_select  out  1 each  datapath controls
alu_instruction  out  ALU_W  ALU opcode
step  out  3  current T-step (0–5), 7 in IDLE/HALTED/FAULT
halted  out  1  in HALTED
fault  out  1  memory timeout latched
illegal  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset (async, clear_n=0): state IDLE; all outputs 0, step=7, counters 0. Assert mid-step aborts immediately; no partial strobes after release.
- States: IDLE, T0..T5, HALTED, FAULT. IDLE->T0 on run=1.
- Step timing: step counter counts 0..CYC_PER_STEP-1. Selects (PC_select, MDR_select, Gra, Grb, BAout, c_select, Z_LO_select, r_select, inport_select, read, alu_instruction) held the whole step. Enables (MAR/MDR/IR/Y/Z/r/outport_enable, PC_increment_enable) asserted only in the final cycle of the step: exactly one load per step.
- T0: PC_select, MAR_enable. ->T1.
- T1: read held; step does not finish until mem_ready=1 and step counter complete; MDR_enable and PC_increment_enable pulse once on that final cycle. Wait counter increments each cycle mem_ready=0; reaching MEM_TIMEOUT -> FAULT (fault=1, all controls 0, exit only by reset).
- T2: MDR_select, IR_enable. ->T3.
- T3 decodes ir_opcode (registered at T3 entry; later changes ignored):
  ldi: T3 Grb,BAout,Y_enable; T4 c_select, alu_instruction=ALU_ADD, Z_enable; T5 Z_LO_select,Gra,r_enable; ->T0.
  out: T3 Gra,r_select,outport_enable; ->T0.
  in: T3 inport_select,Gra,r_enable; ->T0.
  nop: T3 no controls; ->T0.
  halt: ->HALTED (halted=1); leaves to T0 on rising edge of run only.
  other: illegal pulses 1 cycle in T3, treated as nop.
- run=0 takes effect only at T0 entry: sequencer goes to IDLE instead of T0; an instruction in flight always completes.
- alu_instruction=0 outside T4 of ldi.

Optional Feature:
SEQ_SINGLE_STEP_EN: adds input step_req (1 bit). Defined: after a step's final cycle the FSM holds in that step with all controls deasserted until step_req=1 is sampled, then advances; T1 wait/timeout unaffected. Undefined: port absent, steps advance back-to-back.

Test Plan:
- Reset, run=1, CYC_PER_STEP=1, mem_ready=1, ir_opcode=OP_LDI -> steps 0,1,2,3,4,5,0 on consecutive clocks; MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, r_enable each high exactly 1 cycle; alu_instruction=5'b00001 only in T4.
- CYC_PER_STEP=5, opcode OP_OUT -> each step 5 cycles; PC_select high 5 cycles; MAR_enable high only cycle 5; outport_enable 1 pulse in T3; back to T0 after 20 cycles.
- mem_ready low 3 cycles in T1 -> T1 lasts 4 cycles, single MDR_enable and PC_increment_enable pulse on cycle 4; mem_ready held low 15 cycles -> fault=1, all controls 0 until clear_n.
- ir_opcode=OP_HALT -> halted=1, step=7; run held 1 stays halted; run 0->1 -> T0 next cycle.
- ir_opcode=5'b11111 -> illegal pulse 1 cycle in T3, no enables, next fetch T0.
- clear_n low during T4 of ldi -> Z_enable drops immediately, step=7, IDLE after release.
